perif_gpio_in_filter: RTL and testbench

//  Input-side companion of the IO function selector: filters pad input levels and generates pin-change interrupts.

---
 rtl/perif_gpio_in_filter_if.sv | 21 ++
 rtl/perif_gpio_in_filter.sv | 105 ++++++++++
 tb/tb_perif_gpio_in_filter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/perif_gpio_in_filter_if.sv
// Register bus between a peripheral-bus master and the GPIO input filter.
interface perif_gpio_in_filter_if;
  logic [3:2]  i_addr;
  logic [3:0]  i_be;
  logic        i_wr_en;
  logic [31:0] i_wr_data;
  logic        i_rd_en;
  logic [31:0] o_rd_data;
  logic        o_busy;
  logic        o_ack;

  modport master (
    output i_addr, i_be, i_wr_en, i_wr_data, i_rd_en,
    input  o_rd_data, o_busy, o_ack
  );

  modport slave (
    input  i_addr, i_be, i_wr_en, i_wr_data, i_rd_en,
    output o_rd_data, o_busy, o_ack
  );
endinterface

// File: rtl/perif_gpio_in_filter.sv
// GPIO input conditioning: 2-FF synchroniser, per-pin tick-based debounce,
// rise/fall edge capture into a W1C pending register and an ORed interrupt.
module perif_gpio_in_filter #(
  parameter int p_num_gpios = 24,
  parameter int p_db_div    = 16,
  parameter int p_db_count  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  perif_gpio_in_filter_if.slave  bus,
  input  logic [p_num_gpios-1:0] i_pad_in,
  output logic [p_num_gpios-1:0] o_gpio_filt,
  output logic                   o_irq
);
  localparam int c_pre_w = (p_db_div > 1) ? $clog2(p_db_div) : 1;
  localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(p_db_div - 1);
  localparam logic [3:0] c_cnt_last = 4'(p_db_count - 1);

  logic [p_num_gpios-1:0] sync1_reg, sync2_reg;
  logic [p_num_gpios-1:0] filt_reg, filt_next, filt_d_reg;
  logic [3:0]             cnt_reg  [p_num_gpios];
  logic [3:0]             cnt_next [p_num_gpios];
  logic [c_pre_w-1:0]     pre_reg;
  logic                   tick;
  logic [p_num_gpios-1:0] rise_en_reg, fall_en_reg, pending_reg, pending_next;
  logic [p_num_gpios-1:0] wr_bits, wr_mask, clr_bits, edge_bits;
  logic [31:0]            be_mask, rd_mux, rd_data_reg;
  logic                   wr_ack_reg, rd_ack_reg;
  logic                   wr_rise, wr_fall;

  assign tick = (pre_reg == c_pre_last);

  // A counter only advances on ticks while the synchronised level disagrees
  // with the accepted level; any agreement restarts the count.
  generate
    for (genvar gi = 0; gi < p_num_gpios; gi++) begin : g_db
      logic mismatch;
      logic accept;
      assign mismatch = sync2_reg[gi] ^ filt_reg[gi];
      assign accept   = tick & mismatch & (cnt_reg[gi] == c_cnt_last);
      assign filt_next[gi] = accept ? sync2_reg[gi] : filt_reg[gi];
      assign cnt_next[gi]  = !mismatch ? 4'd0 :
                             !tick     ? cnt_reg[gi] :
                             accept    ? 4'd0 : cnt_reg[gi] + 4'd1;
    end
  endgenerate

  assign be_mask = {{8{bus.i_be[3]}}, {8{bus.i_be[2]}}, {8{bus.i_be[1]}}, {8{bus.i_be[0]}}};
  assign wr_mask = p_num_gpios'(be_mask);
  assign wr_bits = p_num_gpios'(bus.i_wr_data & be_mask);
  assign wr_rise = bus.i_wr_en && (bus.i_addr == 2'd1);
  assign wr_fall = bus.i_wr_en && (bus.i_addr == 2'd2);
  assign clr_bits = (bus.i_wr_en && (bus.i_addr == 2'd3)) ? wr_bits : '0;

  // Set is applied after clear so a coincident event keeps the bit pending.
  assign edge_bits = (filt_reg & ~filt_d_reg & rise_en_reg) |
                     (~filt_reg & filt_d_reg & fall_en_reg);
  assign pending_next = (pending_reg & ~clr_bits) | edge_bits;

  always_comb begin
    rd_mux = 32'd0;
    case (bus.i_addr)
      2'd0:    rd_mux = 32'(filt_reg);
      2'd1:    rd_mux = 32'(rise_en_reg);
      2'd2:    rd_mux = 32'(fall_en_reg);
      default: rd_mux = 32'(pending_reg);
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_reg   <= '0;
      sync2_reg   <= '0;
      filt_reg    <= '0;
      filt_d_reg  <= '0;
      pre_reg     <= '0;
      rise_en_reg <= '0;
      fall_en_reg <= '0;
      pending_reg <= '0;
      rd_data_reg <= 32'd0;
      wr_ack_reg  <= 1'b0;
      rd_ack_reg  <= 1'b0;
      for (int i = 0; i < p_num_gpios; i++) cnt_reg[i] <= 4'd0;
    end else begin
      sync1_reg   <= i_pad_in;
      sync2_reg   <= sync1_reg;
      filt_reg    <= filt_next;
      filt_d_reg  <= filt_reg;
      pre_reg     <= tick ? '0 : pre_reg + 1'b1;
      pending_reg <= pending_next;
      wr_ack_reg  <= 1'b1;
      rd_ack_reg  <= 1'b1;
      for (int i = 0; i < p_num_gpios; i++) cnt_reg[i] <= cnt_next[i];
      if (wr_rise) rise_en_reg <= (rise_en_reg & ~wr_mask) | wr_bits;
      if (wr_fall) fall_en_reg <= (fall_en_reg & ~wr_mask) | wr_bits;
      if (bus.i_rd_en) rd_data_reg <= rd_mux;
    end
  end

  assign o_gpio_filt   = filt_reg;
  assign o_irq         = |(pending_reg & (rise_en_reg | fall_en_reg));
  assign bus.o_rd_data = rd_data_reg;
  assign bus.o_busy    = 1'b0;
  assign bus.o_ack     = (bus.i_wr_en & wr_ack_reg) | (bus.i_rd_en & rd_ack_reg);
endmodule

// File: tb/tb_perif_gpio_in_filter.sv
// Directed and randomized bench for perif_gpio_in_filter against a cycle-level reference model.
module tb_perif_gpio_in_filter;
  localparam int NG  = 24;
  localparam int DIV = 4;
  localparam int DBC = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NG-1:0] pads = '1;
  logic [NG-1:0] filt;
  logic          irq;
  int            checks = 0;
  int            errors = 0;

  perif_gpio_in_filter_if bus ();

  perif_gpio_in_filter #(.p_num_gpios(NG), .p_db_div(DIV), .p_db_count(DBC)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus),
    .i_pad_in(pads), .o_gpio_filt(filt), .o_irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: filt flips once the synchronised pad has disagreed with it
  // through DBC prescaler ticks in an unbroken run.
  logic [NG-1:0] m_filt, m_filt_d, m_sync1, m_sync2, m_rise, m_fall, m_pend;
  int            m_run [NG];
  int            m_cyc;

  always @(posedge clk) begin : model
    logic [NG-1:0] nf, ev, clr, bm, wd;
    logic          tk;
    if (rst) begin
      m_filt = '0; m_filt_d = '0; m_sync1 = '0; m_sync2 = '0;
      m_rise = '0; m_fall = '0; m_pend = '0; m_cyc = 0;
      for (int i = 0; i < NG; i++) m_run[i] = 0;
    end else begin
      tk = (m_cyc % DIV) == DIV - 1;
      m_cyc++;
      nf = m_filt;
      for (int i = 0; i < NG; i++) begin
        if (m_sync2[i] == m_filt[i]) m_run[i] = 0;
        else if (tk) begin
          m_run[i]++;
          if (m_run[i] == DBC) begin
            nf[i] = ~m_filt[i];
            m_run[i] = 0;
          end
        end
      end
      ev = (m_filt & ~m_filt_d & m_rise) | (~m_filt & m_filt_d & m_fall);
      bm = NG'({{8{bus.i_be[3]}}, {8{bus.i_be[2]}}, {8{bus.i_be[1]}}, {8{bus.i_be[0]}}});
      wd = NG'(bus.i_wr_data) & bm;
      clr = (bus.i_wr_en && bus.i_addr == 2'd3) ? wd : '0;
      m_pend = (m_pend & ~clr) | ev;
      if (bus.i_wr_en && bus.i_addr == 2'd1) m_rise = (m_rise & ~bm) | wd;
      if (bus.i_wr_en && bus.i_addr == 2'd2) m_fall = (m_fall & ~bm) | wd;
      m_filt_d = m_filt;
      m_filt = nf;
      m_sync2 = m_sync1;
      m_sync1 = pads;
    end
  end

  function automatic logic [31:0] model_reg(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_filt);
      2'd1:    return 32'(m_rise);
      2'd2:    return 32'(m_fall);
      default: return 32'(m_pend);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("filt_model", 32'(filt), 32'(m_filt));
    chk("irq_model", 32'(irq), 32'(|(m_pend & (m_rise | m_fall))));
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
    bus.i_addr = a; bus.i_be = be; bus.i_wr_data = d; bus.i_wr_en = 1'b1;
    #1 chk("wr_ack", 32'(bus.o_ack), 32'd1);
    step();
    bus.i_wr_en = 1'b0;
    $display("WR addr=%0d be=%b data=%h", a, be, d);
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    logic [31:0] exp;
    bus.i_addr = a; bus.i_rd_en = 1'b1;
    exp = model_reg(a);
    #1 chk("rd_ack", 32'(bus.o_ack), 32'd1);
    step();
    bus.i_rd_en = 1'b0;
    chk("rd_model", bus.o_rd_data, exp);
    d = bus.o_rd_data;
    $display("RD addr=%0d data=%h", a, d);
  endtask

  task automatic wait_bit(input int pin, input logic val, input int maxc, output int n);
    n = 0;
    while (filt[pin] !== val && n <= maxc) begin
      step();
      n++;
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] d;
    int          n;
    logic        seen;
    bus.i_addr = 2'd0; bus.i_be = 4'h0; bus.i_wr_data = 32'd0;
    bus.i_wr_en = 1'b0; bus.i_rd_en = 1'b0;

    // 1: reset with all pads high
    bus.i_wr_en = 1'b1; bus.i_rd_en = 1'b1; bus.i_addr = 2'd1;
    bus.i_be = 4'hF; bus.i_wr_data = 32'hFFFF_FFFF;
    step(); step();
    chk("rst_filt", 32'(filt), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_ack", 32'(bus.o_ack), 32'd0);
    chk("rst_rd_data", bus.o_rd_data, 32'd0);
    bus.i_wr_en = 1'b0; bus.i_rd_en = 1'b0;
    rst = 1'b0;
    n = 0;
    while (filt !== 24'hFFFFFF && n <= 14) begin step(); n++; end
    chk("rel_filt_lat_ok", 32'(n <= 14), 32'd1);
    chk("rel_filt", 32'(filt), 32'h00FFFFFF);
    bus_rd(2'd3, d); chk("rel_pending", d, 32'd0);

    // 2: rising edge interrupt on pin 0
    pads = '0;
    n = 0;
    while (filt !== 24'h0 && n <= 20) begin step(); n++; end
    chk("all_low", 32'(filt), 32'd0);
    bus_wr(2'd1, 4'hF, 32'h1);
    pads[0] = 1'b1;
    wait_bit(0, 1'b1, 14, n);
    chk("pin0_lat_ok", 32'(n <= 14), 32'd1);
    step();
    chk("pin0_irq", 32'(irq), 32'd1);
    bus_rd(2'd3, d); chk("pin0_pending", d, 32'h1);
    bus_wr(2'd3, 4'hF, 32'h1);
    chk("pin0_irq_clr", 32'(irq), 32'd0);

    // 3: short glitch rejected, long pulse accepted on pin 3
    bus_wr(2'd1, 4'hF, 32'h9);
    seen = 1'b0;
    pads[3] = 1'b1;
    repeat (8) begin step(); seen |= filt[3]; end
    pads[3] = 1'b0;
    repeat (20) begin step(); seen |= filt[3]; end
    chk("glitch_filt3", 32'(seen), 32'd0);
    bus_rd(2'd3, d); chk("glitch_pending", d, 32'd0);
    pads[3] = 1'b1;
    repeat (16) begin step(); seen |= filt[3]; end
    pads[3] = 1'b0;
    wait_bit(3, 1'b0, 20, n);
    chk("pulse_filt3_rose", 32'(seen), 32'd1);
    chk("pulse_filt3_back", 32'(filt[3]), 32'd0);
    bus_rd(2'd3, d); chk("pulse_pending", d, 32'h8);
    bus_wr(2'd3, 4'hF, 32'h8);

    // 4: falling edge on pin 16, then W1C coinciding with a new event
    bus_wr(2'd2, 4'hF, 32'h0001_0000);
    pads[16] = 1'b1; wait_bit(16, 1'b1, 14, n);
    pads[16] = 1'b0; wait_bit(16, 1'b0, 14, n);
    step();
    bus_rd(2'd3, d); chk("fall16_pending", d, 32'h0001_0000);
    bus_wr(2'd3, 4'b0100, 32'h0001_0000);
    bus_rd(2'd3, d); chk("fall16_cleared", d, 32'd0);
    pads[16] = 1'b1; wait_bit(16, 1'b1, 14, n);
    pads[16] = 1'b0; wait_bit(16, 1'b0, 14, n);
    bus_wr(2'd3, 4'b0100, 32'h0001_0000);
    bus_rd(2'd3, d); chk("set_wins", d, 32'h0001_0000);
    chk("set_wins_irq", 32'(irq), 32'd1);
    bus_wr(2'd3, 4'hF, 32'hFFFF_FFFF);

    // 5: byte-enable write
    bus_wr(2'd1, 4'hF, 32'h0);
    bus_wr(2'd1, 4'b0100, 32'hFFFF_FFFF);
    bus_rd(2'd1, d); chk("be_rise_en", d, 32'h00FF_0000);
    bus_rd(2'd0, d); chk("value_rd", d, 32'h0000_0001);

    // 6: reset in the middle of a debounce on pin 5
    pads[5] = 1'b1;
    n = 0;
    while (m_run[5] != 2 && n <= 20) begin step(); n++; end
    chk("pin5_two_ticks", 32'(m_run[5]), 32'd2);
    rst = 1'b1; bus.i_rd_en = 1'b1;
    step(); step();
    chk("rst2_filt", 32'(filt), 32'd0);
    chk("rst2_irq", 32'(irq), 32'd0);
    chk("rst2_ack", 32'(bus.o_ack), 32'd0);
    bus.i_rd_en = 1'b0; rst = 1'b0;
    wait_bit(5, 1'b1, 14, n);
    chk("pin5_lat_min", 32'(n >= 2 + (DBC - 1) * DIV + 1), 32'd1);
    chk("pin5_lat_max", 32'(n <= 2 + DIV * DBC), 32'd1);
    bus_rd(2'd1, d); chk("rst2_rise_en", d, 32'd0);
    bus_rd(2'd2, d); chk("rst2_fall_en", d, 32'd0);
    bus_rd(2'd3, d); chk("rst2_pending", d, 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 0) pads = pads ^ (24'h1 << $urandom_range(0, 3));
        else pads = pads ^ (24'h1 << $urandom_range(0, NG - 1));
      end
      case ($urandom_range(0, 7))
        0:       bus_wr(2'($urandom_range(0, 3)), 4'($urandom), $urandom);
        1:       bus_rd(2'($urandom_range(0, 3)), d);
        default: step();
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
